// File: rtl/mvm_param_lanes.sv
// mvm_param_lanes: P-lane signed K x K matrix-vector multiplier y = A*x; define MVM_SATURATE_EN to clamp results to OW bits instead of wrapping.
module mvm_param_lanes #(
    parameter int K  = 8,
    parameter int P  = 2,
    parameter int B  = 8,
    parameter int OW = 2*B+$clog2(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 loadMatrix,
    input  logic                 loadVector,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [B-1:0]  data_in,
    output logic signed [OW-1:0] data_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = 2*B+$clog2(K);
    localparam int NP = K/P;
    localparam int CW = $clog2(K);
    localparam int PW = P > 1 ? $clog2(P) : 1;
    localparam int RW = NP > 1 ? $clog2(NP) : 1;
    localparam int TW = $clog2(K+3);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT, DONE} state_t;
    state_t state, state_nx;
    logic signed [B-1:0]    a_mem [P][NP][K];
    logic signed [B-1:0]    x_mem [K];
    logic signed [OW-1:0]   y_mem [K];
    logic signed [B-1:0]    a_rd [P];
    logic signed [B-1:0]    x_rd;
    logic signed [2*B-1:0]  prod [P];
    logic signed [AW-1:0]   acc [P];
    logic [CW-1:0] col, rd_col;
    logic [PW-1:0] bank;
    logic [RW-1:0] row;
    logic [TW-1:0] cnt;
    logic last_col, last_bank, last_row, last_cnt;
    assign last_col  = col == CW'(K-1);
    assign last_bank = bank == PW'(P-1);
    assign last_row  = row == RW'(NP-1);
    assign last_cnt  = cnt == TW'(K+2);
    assign rd_col    = cnt < TW'(K) ? cnt[CW-1:0] : '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign out_valid = state == OUTPUT;
    assign data_out  = out_valid ? y_mem[col] : '0;

    function automatic logic signed [OW-1:0] reduce(input logic signed [AW-1:0] v);
`ifdef MVM_SATURATE_EN
        logic signed [AW-1:0] max_v = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        logic signed [AW-1:0] min_v = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        return v > max_v ? OW'(max_v) : v < min_v ? OW'(min_v) : v[OW-1:0];
`else
        return v[OW-1:0];
`endif
    endfunction

    // next-state: start wins over loads in IDLE, each busy state runs to its own end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? COMPUTE : loadMatrix ? LOAD_A : loadVector ? LOAD_X : IDLE;
            LOAD_A:  state_nx = in_valid && last_col && last_bank && last_row ? IDLE : LOAD_A;
            LOAD_X:  state_nx = in_valid && last_col ? IDLE : LOAD_X;
            COMPUTE: state_nx = last_cnt && last_row ? OUTPUT : COMPUTE;
            OUTPUT:  state_nx = last_col ? DONE : OUTPUT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state and counters; every counter wraps to zero at the end of its state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            col   <= '0;
            bank  <= '0;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if ((state == LOAD_A || state == LOAD_X) && in_valid || state == OUTPUT)
                col <= last_col ? '0 : col + 1'b1;
            if (state == LOAD_A && in_valid && last_col) begin
                bank <= last_bank ? '0 : bank + 1'b1;
                if (last_bank) row <= last_row ? '0 : row + 1'b1;
            end
            if (state == COMPUTE) begin
                cnt <= last_cnt ? '0 : cnt + 1'b1;
                if (last_cnt) row <= last_row ? '0 : row + 1'b1;
            end
        end
    end

    // memories: row r of A lives in bank r mod P, y gets all lanes at pass end
    always_ff @(posedge clk) begin
        if (state == LOAD_A && in_valid) a_mem[bank][row][col] <= data_in;
        if (state == LOAD_X && in_valid) x_mem[col] <= data_in;
        if (state == COMPUTE && last_cnt)
            for (int j = 0; j < P; j++) y_mem[CW'(int'(row)*P + j)] <= reduce(acc[j]);
    end

    // lane pipeline: read at cnt, product at cnt+1, accumulate at cnt+2
    always_ff @(posedge clk) begin
        x_rd <= x_mem[rd_col];
        for (int j = 0; j < P; j++) begin
            a_rd[j] <= a_mem[j][row][rd_col];
            prod[j] <= (2*B)'(a_rd[j]) * (2*B)'(x_rd);
            if (reset || cnt == '0)
                acc[j] <= '0;
            else if (cnt >= TW'(2) && cnt <= TW'(K+1))
                acc[j] <= acc[j] + AW'(prod[j]);
        end
    end
endmodule
